axi4_lite_reg_responder: RTL and testbench
==========================================

// Module: axi4_lite_reg_responder
// PURPOSE
//  AXI4-Lite slave-side responder backed by a NUM_REGS x DATA_WIDTH register file.
//  Completes AW/W/B write transactions and AR/R read transactions issued by axi4_lite_master.
//  Serves as the synthesizable responder end of the master/BFM pair in the OOTB environment.
//  Write and read channels operate independently and may proceed concurrently.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width (AWADDR/ARADDR)
//  DATA_WIDTH  32  data width; must be 32 or 64
//  NUM_REGS    16  register count; power of 2, >= 2
// PORTS
//  ACLK     in   1             clock; all logic on rising edge
//  ARESET   in   1             reset, synchronous, active-high
//  AWADDR   in   ADDR_WIDTH    write address
//  AWVALID  in   1             write address valid
//  AWREADY  out  1             write address ready
//  WDATA    in   DATA_WIDTH    write data
//  WSTRB    in   DATA_WIDTH/8  byte-lane write strobes
//  WVALID   in   1             write data valid
//  WREADY   out  1             write data ready
//  BRESP    out  2             write response (00 OKAY, 10 SLVERR)
//  BVALID   out  1             write response valid
//  BREADY   in   1             write response ready
//  ARADDR   in   ADDR_WIDTH    read address
//  ARVALID  in   1             read address valid
//  ARREADY  out  1             read address ready
//  RDATA    out  DATA_WIDTH    read data
//  RRESP    out  2             read response
//  RVALID   out  1             read data valid
//  RREADY   in   1             read data ready
// BEHAVIOUR
//  - Reset (ARESET=1 at edge): all registers 0; AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0.
//    Mid-transaction reset aborts it; no response is issued afterwards. READYs assert on the first edge after reset releases.
//  - Index = ADDR[OFS +: log2(NUM_REGS)], OFS = log2(DATA_WIDTH/8). Low OFS bits are ignored.
//  - Write FSM states:
//    - W_IDLE: AWREADY=1, WREADY=1.
//      - AW only: latch addr, go to W_WAIT_D (AWREADY=0).
//      - W only: latch data/strb, go to W_WAIT_A (WREADY=0).
//      - Both in the same cycle: go to W_RESP.
//    - W_WAIT_D: on W handshake, go to W_RESP.
//    - W_WAIT_A: on AW handshake, go to W_RESP.
//    - Commit: the register write (per-byte WSTRB merge) takes effect at the edge entering W_RESP.
//    - W_RESP: BVALID=1, BRESP stable, both READYs 0. On BVALID&&BREADY go to W_IDLE.
//    - Minimum write latency: B valid 1 cycle after the last of AW/W.
//    - BVALID never depends combinationally on BREADY.
//  - Read FSM states:
//    - R_IDLE: ARREADY=1. On AR handshake, register RDATA/RRESP from the current file and go to R_DATA.
//    - R_DATA: RVALID=1, ARREADY=0, RDATA held until RVALID&&RREADY, then go to R_IDLE.
//    - Read latency: RVALID 1 cycle after the AR handshake.
//  - Same-edge read and write commit to the same index: read returns the pre-write value.
//  - WSTRB=0: write completes with OKAY and the register is unchanged.
// CONFIGURATION
//  AXI4_LITE_RESP_SLVERR_EN defined:
//    - Address with any bit above index+OFS nonzero is out-of-range.
//    - Out-of-range write: no register change, BRESP=10.
//    - Out-of-range read: RDATA=0, RRESP=10.
//  Undefined: upper bits ignored (index wraps modulo NUM_REGS); BRESP/RRESP always 00.
// TESTING
//  1 AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF -> BVALID next cycle, BRESP 00; read 0x08 -> RDATA 0xDEADBEEF.
//  2 W 3 cycles before AW, addr 0x04, data 0x11223344 -> WREADY low while waiting; one B; readback 0x11223344.
//  3 Reg 0x0C=0xAABBCCDD, write 0x0000EE00 strb 0x2 -> readback 0xAABBEEDD.
//  4 BREADY low 5 cycles, RREADY low 4 cycles -> BVALID/RVALID, BRESP, RDATA held stable; no new AW/AR accepted.
//  5 ARESET pulse while in W_WAIT_D -> BVALID stays 0; all regs read back 0.
//  6 Write addr 0x40 (NUM_REGS=16): with _EN BRESP 10, reg 0 unchanged; without, reg 0 written, BRESP 00.

Source files
------------

// File: rtl/axi4_lite_reg_responder.sv
// AXI4-Lite slave backed by a NUM_REGS x DATA_WIDTH register file; write and read channels run independently.
// Optional macro AXI4_LITE_RESP_SLVERR_EN: out-of-range addresses are rejected with SLVERR instead of wrapping.
module axi4_lite_reg_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] addr_lat;
  logic [DATA_WIDTH-1:0] data_lat;
  logic [STRB_W-1:0]     strb_lat;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;
  logic                  commit_err;
  logic                  rd_err;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFS +: IDX_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] strb_merge(input logic [DATA_WIDTH-1:0] old_val,
                                                       input logic [DATA_WIDTH-1:0] new_val,
                                                       input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

`ifdef AXI4_LITE_RESP_SLVERR_EN
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return |(a >> (OFS + IDX_W));
  endfunction

  assign commit_err = addr_err(commit_addr);
  assign rd_err     = addr_err(ARADDR);
`else
  assign commit_err = 1'b0;
  assign rd_err     = 1'b0;
`endif

  // Byte-offset bits (and upper bits when wrapping) are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{AWADDR, ARADDR};

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // The write commits on whichever edge completes the second of the AW/W handshakes.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = AWADDR;
    commit_data = WDATA;
    commit_strb = WSTRB;
    case (wstate)
      W_IDLE:   commit_en = aw_hs && w_hs;
      W_WAIT_D: begin
        commit_en   = w_hs;
        commit_addr = addr_lat;
      end
      W_WAIT_A: begin
        commit_en   = aw_hs;
        commit_data = data_lat;
        commit_strb = strb_lat;
      end
      default: commit_en = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_en && !commit_err) begin
      regs[addr_idx(commit_addr)] <= strb_merge(regs[addr_idx(commit_addr)], commit_data, commit_strb);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (commit_en) begin
            wstate  <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= commit_err ? 2'b10 : 2'b00;
          end else if (aw_hs) begin
            wstate   <= W_WAIT_D;
            addr_lat <= AWADDR;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
          end else if (w_hs) begin
            wstate   <= W_WAIT_A;
            data_lat <= WDATA;
            strb_lat <= WSTRB;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b0;
          end else begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        W_WAIT_D, W_WAIT_A: begin
          if (commit_en) begin
            wstate  <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= commit_err ? 2'b10 : 2'b00;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            wstate  <= W_IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // RDATA samples the file before any same-edge commit lands, so reads see the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RRESP   <= 2'b00;
      RDATA   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate  <= R_DATA;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= rd_err ? '0 : regs[addr_idx(ARADDR)];
            RRESP   <= rd_err ? 2'b10 : 2'b00;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rstate  <= R_IDLE;
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_responder.sv
// Randomized self-checking bench for axi4_lite_reg_responder against a byte-level register model.
// Honours AXI4_LITE_RESP_SLVERR_EN the same way the design does.
module tb_axi4_lite_reg_responder;

  localparam int NR = 16;
`ifdef AXI4_LITE_RESP_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [NR];

  always #5 ACLK = ~ACLK;

  axi4_lite_reg_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Reference model: word-addressed array, wrapping or rejecting addresses beyond the file.
  function automatic bit m_oor(input logic [31:0] a);
    return SLVERR_EN && (a >= NR * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_oor(a) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_oor(a) ? 32'h0 : mem[m_idx(a)];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_oor(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NR; i++) mem[i] = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp, output int blat);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_f, w_f;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge ACLK);
      if (aw_f) aw_done = 1'b1;
      if (w_f) w_done = 1'b1;
      cyc++;
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    blat = 0;
    while (!BVALID && blat < 20) begin
      @(posedge ACLK); @(negedge ACLK); blat++;
    end
    tests++;
    if (BVALID !== 1'b1) begin
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, BVALID);
      fails++;
    end
    resp = BRESP;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int rlat);
    int n = 0;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    while (!ARREADY && n < 20) begin
      @(posedge ACLK); @(negedge ACLK); n++;
    end
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    rlat = 0;
    while (!RVALID && rlat < 20) begin
      @(posedge ACLK); @(negedge ACLK); rlat++;
    end
    tests++;
    if (RVALID !== 1'b1) begin
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, RVALID);
      fails++;
    end
    d = RDATA; resp = RRESP;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ACLK); ARESET = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      $display("FAIL reset_ctrl got=%b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
      fails++;
    end
    tests++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      $display("FAIL reset_data bresp=%b rresp=%b rdata=%h required 0", BRESP, RRESP, RDATA);
      fails++;
    end
    ARESET = 1'b0;
    m_clear();
    @(posedge ACLK); @(negedge ACLK);
    tests++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      $display("FAIL reset_release_ready got=%b required 111", {AWREADY, WREADY, ARREADY});
      fails++;
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
    m_write(32'h08, 32'hDEADBEEF, 4'hF);
    tests++;
    if (resp !== 2'b00 || lat !== 0) begin
      $display("FAIL same_cycle_b resp=%b lat=%0d required 00 lat 0", resp, lat);
      fails++;
    end
    do_read(32'h08, d, resp, lat);
    tests++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00 || lat !== 0) begin
      $display("FAIL same_cycle_read data=%h resp=%b lat=%0d required deadbeef 00 0", d, resp, lat);
      fails++;
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic [31:0] d; int lat;
    int wready_hi = 0;
    int b_count = 0;
    @(negedge ACLK);
    WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      WVALID = 1'b0;
      if (WREADY !== 1'b0) wready_hi++;
      @(posedge ACLK);
    end
    tests++;
    if (wready_hi !== 0) begin
      $display("FAIL w_first_wready_low cycles_high=%0d required 0", wready_hi);
      fails++;
    end
    @(negedge ACLK);
    AWADDR = 32'h04; AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (BVALID === 1'b1) b_count++;
      @(posedge ACLK); @(negedge ACLK);
    end
    BREADY = 1'b0;
    m_write(32'h04, 32'h11223344, 4'hF);
    tests++;
    if (b_count !== 1) begin
      $display("FAIL w_first_b_count got=%0d required 1", b_count);
      fails++;
    end
    do_read(32'h04, d, resp, lat);
    tests++;
    if (d !== 32'h11223344 || resp !== 2'b00) begin
      $display("FAIL w_first_read data=%h resp=%b required 11223344 00", d, resp);
      fails++;
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 1, 0, resp, lat);
    m_write(32'h0C, 32'hAABBCCDD, 4'hF);
    do_write(32'h0C, 32'h0000EE00, 4'h2, 0, 2, resp, lat);
    m_write(32'h0C, 32'h0000EE00, 4'h2);
    do_read(32'h0C, d, resp, lat);
    tests++;
    if (d !== 32'hAABBEEDD) begin
      $display("FAIL strobe_merge data=%h required aabbeedd", d);
      fails++;
    end
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, resp, lat);
    tests++;
    if (resp !== 2'b00) begin
      $display("FAIL strobe_zero_resp resp=%b required 00", resp);
      fails++;
    end
    do_read(32'h0C, d, resp, lat);
    tests++;
    if (d !== 32'hAABBEEDD) begin
      $display("FAIL strobe_zero_data data=%h required aabbeedd", d);
      fails++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] wd;
    int bad = 0;
    wd = $urandom;
    @(negedge ACLK);
    AWADDR = 32'h18; WDATA = wd; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    m_write(32'h18, wd, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) bad++;
      @(posedge ACLK); @(negedge ACLK);
    end
    tests++;
    if (bad !== 0) begin
      $display("FAIL b_hold bad_cycles=%0d required 0", bad);
      fails++;
    end
    BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    tests++;
    if (BVALID !== 1'b0) begin
      $display("FAIL b_release bvalid=%b required 0", BVALID);
      fails++;
    end
    bad = 0;
    ARADDR = 32'h18; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({RVALID, ARREADY, RRESP} !== 4'b1000 || RDATA !== m_read(32'h18)) bad++;
      @(posedge ACLK); @(negedge ACLK);
    end
    tests++;
    if (bad !== 0) begin
      $display("FAIL r_hold bad_cycles=%0d rdata=%h required 0 bad, data %h", bad, RDATA, m_read(32'h18));
      fails++;
    end
    RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
    tests++;
    if (RVALID !== 1'b0) begin
      $display("FAIL r_release rvalid=%b required 0", RVALID);
      fails++;
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] old_v, new_v, d;
    logic [1:0] resp; int lat;
    old_v = m_read(32'h14);
    new_v = $urandom;
    @(negedge ACLK);
    AWADDR = 32'h14; WDATA = new_v; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h14; ARVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tests++;
    if (RVALID !== 1'b1 || BVALID !== 1'b1 || RDATA !== old_v) begin
      $display("FAIL concurrent_prewrite rvalid=%b bvalid=%b rdata=%h required 1 1 %h", RVALID, BVALID, RDATA, old_v);
      fails++;
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    m_write(32'h14, new_v, 4'hF);
    do_read(32'h14, d, resp, lat);
    tests++;
    if (d !== new_v) begin
      $display("FAIL concurrent_after data=%h required %h", d, new_v);
      fails++;
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 1, resp, lat);
    tests++;
    if (resp !== m_resp(32'h40)) begin
      $display("FAIL oor_bresp resp=%b required %b", resp, m_resp(32'h40));
      fails++;
    end
    m_write(32'h40, 32'hCAFEF00D, 4'hF);
    do_read(32'h00, d, resp, lat);
    tests++;
    if (d !== m_read(32'h00) || resp !== 2'b00) begin
      $display("FAIL oor_reg0 data=%h resp=%b required %h 00", d, resp, m_read(32'h00));
      fails++;
    end
    do_read(32'h48, d, resp, lat);
    tests++;
    if (d !== m_read(32'h48) || resp !== m_resp(32'h48)) begin
      $display("FAIL oor_read data=%h resp=%b required %h %b", d, resp, m_read(32'h48), m_resp(32'h48));
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; int lat;
    int bv = 0;
    int nz = 0;
    @(negedge ACLK);
    AWADDR = 32'h08; AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    tests++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
      $display("FAIL wait_d_state awready=%b wready=%b required 0 1", AWREADY, WREADY);
      fails++;
    end
    ARESET = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    m_clear();
    BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (BVALID !== 1'b0) bv++;
      @(posedge ACLK); @(negedge ACLK);
    end
    BREADY = 1'b0;
    tests++;
    if (bv !== 0) begin
      $display("FAIL reset_abort_bvalid cycles_high=%0d required 0", bv);
      fails++;
    end
    for (int i = 0; i < NR; i++) begin
      do_read(32'(i * 4), d, resp, lat);
      if (d !== 32'h0) nz++;
    end
    tests++;
    if (nz !== 0) begin
      $display("FAIL reset_regs_zero nonzero_regs=%0d required 0", nz);
      fails++;
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] a, d, got; logic [3:0] s; int lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, NR * 8 - 1);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
        tests++;
        if (resp !== m_resp(a) || lat !== 0) begin
          $display("FAIL rand_write addr=%h resp=%b lat=%0d required %b lat 0", a, resp, lat, m_resp(a));
          fails++;
        end
        m_write(a, d, s);
      end else begin
        do_read(a, got, resp, lat);
        tests++;
        if (got !== m_read(a) || resp !== m_resp(a) || lat !== 0) begin
          $display("FAIL rand_read addr=%h data=%h resp=%b lat=%0d required %h %b lat 0", a, got, resp, lat, m_read(a), m_resp(a));
          fails++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_strobe();
    test_backpressure();
    test_concurrent();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
